// File: rtl/plic_lite.sv
// rtl/plic_lite.sv - single-context platform-level interrupt controller with claim/complete bus slave
module plic_lite #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            bus_valid,
    input  logic            bus_we,
    input  logic [11:0]     bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            bus_ready,
    output logic            irq_ext
);
    localparam logic [4:0] NSRC_ID = 5'(NSRC);

    typedef enum logic {S_IDLE, S_RESP} state_e;
    state_e state_q, state_d;

    // Per-source state is indexed by ID-1 so it lines up with irq_src.
    logic [PRIO_W-1:0] prio_q [NSRC];
    logic [PRIO_W-1:0] prio_d [NSRC];
    logic [NSRC-1:0]   enable_q, enable_d;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   inflight_q, inflight_d;
    logic [PRIO_W-1:0] threshold_q, threshold_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic        accept;
    logic [9:0]  word;
    logic [4:0]  prio_idx;
    logic        is_prio, is_pend, is_en, is_thr, is_claim;
    logic [4:0]  win_id;
    logic [PRIO_W-1:0] win_prio;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign accept      = bus_valid && (state_q == S_IDLE);
    assign word        = bus_addr[11:2];
    assign prio_idx    = word[4:0];
    assign is_prio     = (word[9:5] == 5'd0) && (prio_idx != 5'd0) && (prio_idx <= NSRC_ID);
    assign is_pend     = (word == 10'h020);
    assign is_en       = (word == 10'h040);
    assign is_thr      = (word == 10'h080);
    assign is_claim    = (word == 10'h081);
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    // Strict compare against the running best gives ties to the lowest ID
    // and makes the threshold the bar every candidate must exceed.
    always_comb begin
        win_id   = 5'd0;
        win_prio = threshold_q;
        for (int i = 0; i < NSRC; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > win_prio)) begin
                win_id   = 5'(i + 1);
                win_prio = prio_q[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_prio) begin
            for (int i = 0; i < NSRC; i++) begin
                if (prio_idx == 5'(i + 1)) rd_val[PRIO_W-1:0] = prio_q[i];
            end
        end else if (is_pend) begin
            rd_val[NSRC:0] = {pending_q, 1'b0};
        end else if (is_en) begin
            rd_val[NSRC:0] = {enable_q, 1'b0};
        end else if (is_thr) begin
            rd_val[PRIO_W-1:0] = threshold_q;
        end else if (is_claim) begin
            rd_val[4:0] = win_id;
        end
    end

    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        threshold_d = threshold_q;
        // Gateway: only idle sources (neither pending nor in flight) can trigger.
        pending_d   = pending_q | (irq_src & ~pending_q & ~inflight_q);
        inflight_d  = inflight_q;
        rdata_d     = '0;
        irq_d       = (win_id != 5'd0);
        if (accept) begin
            if (bus_we) begin
                for (int i = 0; i < NSRC; i++) begin
                    if (is_prio && (prio_idx == 5'(i + 1))) prio_d[i] = bus_wdata[PRIO_W-1:0];
                    if (is_claim && (bus_wdata[4:0] == 5'(i + 1))) inflight_d[i] = 1'b0;
                end
                if (is_en)  enable_d    = bus_wdata[NSRC:1];
                if (is_thr) threshold_d = bus_wdata[PRIO_W-1:0];
            end else begin
                rdata_d = rd_val;
                if (is_claim) begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (win_id == 5'(i + 1)) begin
                            pending_d[i]  = 1'b0;
                            inflight_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus_valid) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with rst drops the strobe of a transfer that reset is aborting.
    always_comb begin
        bus_ready = (state_q == S_RESP) && !rst;
        bus_rdata = rdata_q;
        irq_ext   = irq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '{default: '0};
            enable_q    <= '0;
            pending_q   <= '0;
            inflight_q  <= '0;
            threshold_q <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            inflight_q  <= inflight_d;
            threshold_q <= threshold_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end
endmodule

// File: tb/tb_plic_lite.sv
// tb/tb_plic_lite.sv - directed self-checking bench for plic_lite
module tb_plic_lite;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        bus_valid;
    logic        bus_we;
    logic [11:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        irq_ext;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    plic_lite #(.NSRC(8), .PRIO_W(3)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .irq_ext(irq_ext)
    );

    task automatic bus_xfer(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        bit done = 1'b0;
        bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        for (int c = 0; c < 8 && !done; c++) begin
            @(posedge clk); #1;
            if (bus_ready) done = 1'b1;
        end
        rdata = bus_rdata;
        bus_valid = 1'b0; bus_we = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL bus_timeout addr=%h ready=0 required=1", addr);
        end
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data);
        bus_xfer(1'b0, addr, 32'h0, data);
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_src = '0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        vectors++;
        if (irq_ext !== 1'b0 || bus_ready !== 1'b0 || bus_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got irq=%b ready=%b rdata=%h exp 0/0/0", irq_ext, bus_ready, bus_rdata);
        end
        rd(12'h080, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_pending got=%h exp=%h", d, 32'h0); end
        rd(12'h100, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_enable got=%h exp=%h", d, 32'h0); end
        rd(12'h200, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_threshold got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_register_map();
        logic [31:0] d;
        do_reset();
        wr(12'h000, 32'h7); rd(12'h000, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL prio0_reads_zero got=%h exp=%h", d, 32'h0); end
        wr(12'h00C, 32'hFF); rd(12'h00C, d); vectors++;
        if (d !== 32'h7) begin miscompares++; $display("FAIL prio3_masked got=%h exp=%h", d, 32'h7); end
        wr(12'h024, 32'h7); rd(12'h024, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL prio9_unmapped got=%h exp=%h", d, 32'h0); end
        wr(12'h100, 32'hFFFF_FFFF); rd(12'h100, d); vectors++;
        if (d !== 32'h1FE) begin miscompares++; $display("FAIL enable_mask got=%h exp=%h", d, 32'h1FE); end
        wr(12'h200, 32'hF); rd(12'h200, d); vectors++;
        if (d !== 32'h7) begin miscompares++; $display("FAIL threshold_mask got=%h exp=%h", d, 32'h7); end
        wr(12'h300, 32'h5); rd(12'h300, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_single_source();
        logic [31:0] d;
        do_reset();
        wr(12'h00C, 32'h2); wr(12'h100, 32'h08); wr(12'h200, 32'h0);
        irq_src = 8'h04;
        @(posedge clk); #1 irq_src = 8'h00;
        vectors++;
        if (irq_ext !== 1'b0) begin miscompares++; $display("FAIL single_irq_early got=%b exp=0", irq_ext); end
        @(posedge clk); #1;
        vectors++;
        if (irq_ext !== 1'b1) begin miscompares++; $display("FAIL single_irq_rise got=%b exp=1", irq_ext); end
        rd(12'h204, d); vectors++;
        if (d !== 32'd3) begin miscompares++; $display("FAIL single_claim got=%0d exp=3", d); end
        @(posedge clk); #1;
        vectors++;
        if (irq_ext !== 1'b0) begin miscompares++; $display("FAIL single_irq_drop got=%b exp=0", irq_ext); end
        wr(12'h204, 32'd3);
        rd(12'h080, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL single_pending_clear got=%h exp=0", d); end
        irq_src = 8'h04;
        @(posedge clk); #1 irq_src = 8'h00;
        rd(12'h080, d); vectors++;
        if (d !== 32'h08) begin miscompares++; $display("FAIL single_rearm got=%h exp=%h", d, 32'h08); end
    endtask

    task automatic test_priority_tie();
        logic [31:0] d;
        logic [31:0] exp_ids [4];
        exp_ids = '{32'd6, 32'd2, 32'd5, 32'd0};
        do_reset();
        wr(12'h008, 32'h5); wr(12'h014, 32'h5); wr(12'h018, 32'h7);
        wr(12'h100, 32'h64); wr(12'h200, 32'h0);
        irq_src = 8'b0011_0010;
        @(posedge clk); #1 irq_src = 8'h00;
        repeat (2) @(posedge clk); #1;
        rd(12'h080, d); vectors++;
        if (d !== 32'h64) begin miscompares++; $display("FAIL tie_pending got=%h exp=%h", d, 32'h64); end
        for (int k = 0; k < 4; k++) begin
            rd(12'h204, d); vectors++;
            if (d !== exp_ids[k]) begin
                miscompares++;
                $display("FAIL tie_claim%0d got=%0d exp=%0d", k, d, exp_ids[k]);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (irq_ext !== 1'b0) begin miscompares++; $display("FAIL tie_irq_idle got=%b exp=0", irq_ext); end
    endtask

    task automatic test_threshold();
        do_reset();
        wr(12'h004, 32'h3); wr(12'h100, 32'h02); wr(12'h200, 32'h3);
        irq_src = 8'h01;
        @(posedge clk); #1 irq_src = 8'h00;
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (irq_ext !== 1'b0) begin miscompares++; $display("FAIL thr_equal_blocks got=%b exp=0", irq_ext); end
        wr(12'h200, 32'h2);
        vectors++;
        if (irq_ext !== 1'b0) begin miscompares++; $display("FAIL thr_reg_stage got=%b exp=0", irq_ext); end
        @(posedge clk); #1;
        vectors++;
        if (irq_ext !== 1'b1) begin miscompares++; $display("FAIL thr_lowered got=%b exp=1", irq_ext); end
    endtask

    task automatic test_level_hold();
        logic [31:0] d;
        do_reset();
        wr(12'h010, 32'h1); wr(12'h100, 32'h10); wr(12'h200, 32'h0);
        irq_src = 8'h08;
        repeat (2) @(posedge clk); #1;
        rd(12'h204, d); vectors++;
        if (d !== 32'd4) begin miscompares++; $display("FAIL level_claim1 got=%0d exp=4", d); end
        wr(12'h204, 32'd4);
        repeat (2) @(posedge clk); #1;
        rd(12'h204, d); vectors++;
        if (d !== 32'd4) begin miscompares++; $display("FAIL level_repend got=%0d exp=4", d); end
        wr(12'h204, 32'd9);
        repeat (2) @(posedge clk); #1;
        rd(12'h080, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL level_bogus_complete got=%h exp=0", d); end
        vectors++;
        if (irq_ext !== 1'b0) begin miscompares++; $display("FAIL level_bogus_irq got=%b exp=0", irq_ext); end
        irq_src = 8'h00;
        wr(12'h204, 32'd4);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 12'h100;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus_ready !== ((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL b2b_ready_cycle%0d got=%b exp=%b", i, bus_ready, (i % 2) == 0);
            end
        end
        bus_valid = 1'b0;
        @(posedge clk); #1;
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 12'h100; bus_wdata = 32'hFF;
        @(posedge clk); #1;
        vectors++;
        if (bus_ready !== 1'b1) begin miscompares++; $display("FAIL abort_accept got=%b exp=1", bus_ready); end
        rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0;
        #1;
        vectors++;
        if (bus_ready !== 1'b0) begin miscompares++; $display("FAIL abort_no_ready got=%b exp=0", bus_ready); end
        @(posedge clk); #1;
        vectors++;
        if (bus_ready !== 1'b0) begin miscompares++; $display("FAIL abort_after got=%b exp=0", bus_ready); end
        rst = 1'b0;
        rd(12'h100, d); vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL abort_state_cleared got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_register_map();
        test_single_source();
        test_priority_tie();
        test_threshold();
        test_level_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
